// File: rtl/ann_pkg.sv
// Shared constants and state encoding for the ANN neuron blocks.
package ann_pkg;
  localparam int N_IN  = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 2 * DW + AW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/ann_sat_shift.sv
// Converts a wide Q-format accumulator to a DW-bit result:
// arithmetic shift right by FRAC, then clamp to the signed DW range.
module ann_sat_shift #(
  parameter int ACC_W = ann_pkg::ACC_W,
  parameter int DW    = ann_pkg::DW,
  parameter int FRAC  = ann_pkg::FRAC
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [DW-1:0]    y_o
);
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_i >>> FRAC;
    if (shifted > Y_MAX)      y_o = Y_MAX[DW-1:0];
    else if (shifted < Y_MIN) y_o = Y_MIN[DW-1:0];
    else                      y_o = shifted[DW-1:0];
  end
endmodule

// File: rtl/neuron_mac_ctrl.sv
// Single-neuron dot-product controller: loads weights into an external BRAM,
// streams activations against them with a 1 MAC/cycle pipeline, returns a saturated result.
module neuron_mac_ctrl #(
  parameter int N_IN = ann_pkg::N_IN,
  parameter int AW   = ann_pkg::AW,
  parameter int DW   = ann_pkg::DW,
  parameter int FRAC = ann_pkg::FRAC
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  output logic          busy,
  input  logic          x_valid,
  input  logic [DW-1:0] x_data,
  output logic          x_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_err,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_di,
  output logic          bram_en,
  output logic          bram_we,
  input  logic [DW-1:0] bram_do,
  output logic          y_valid,
  output logic [DW-1:0] y_data,
  input  logic          y_ready
);
  import ann_pkg::*;

  localparam int ACC_W = 2 * DW + AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_IN - 1);

  state_t                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic signed [2*DW-1:0]  prod_q, prod_d;
  logic                    pvalid_q, pvalid_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    alive_q;
  logic                    busy_q, x_ready_q, y_valid_q;
  logic signed [2*DW-1:0]  x_ext, w_ext;
  logic signed [DW-1:0]    sat_y;

  ann_sat_shift #(.ACC_W(ACC_W), .DW(DW), .FRAC(FRAC)) u_sat (
    .acc_i (acc_q),
    .y_o   (sat_y)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    prod_d    = prod_q;
    pvalid_d  = 1'b0;
    acc_d     = acc_q;
    ld_ready  = 1'b0;
    ld_err    = 1'b0;
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_di   = '0;
    x_ext     = {{DW{x_data[DW-1]}}, x_data};
    w_ext     = {{DW{bram_do[DW-1]}}, bram_do};

    // Second pipeline stage: fold the product captured on the previous beat.
    if (pvalid_q) acc_d = acc_q + $signed({{(ACC_W-2*DW){prod_q[2*DW-1]}}, prod_q});

    case (state_q)
      IDLE: begin
        // alive_q holds everything quiet for the first cycle out of reset.
        if (alive_q) begin
          if (start) begin
            state_d = RUN;
            idx_d   = '0;
            acc_d   = '0;
            prod_d  = '0;
          end else begin
            ld_ready = 1'b1;
            if (ld_valid) begin
              if (ld_addr <= LAST_IDX) begin
                bram_en   = 1'b1;
                bram_we   = 1'b1;
                bram_addr = ld_addr;
                bram_di   = ld_data;
              end else begin
                ld_err = 1'b1;
              end
            end
          end
        end
      end
      RUN: begin
        bram_addr = idx_q;
        bram_en   = x_valid;
        if (x_valid) begin
          prod_d   = x_ext * w_ext;
          pvalid_d = 1'b1;
          idx_d    = idx_q + AW'(1);
          if (idx_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: state_d = DONE;
      DONE:  if (y_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy    = busy_q;
    x_ready = x_ready_q;
    y_valid = y_valid_q;
    y_data  = y_valid_q ? sat_y : '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      prod_q    <= '0;
      pvalid_q  <= 1'b0;
      acc_q     <= '0;
      alive_q   <= 1'b0;
      busy_q    <= 1'b0;
      x_ready_q <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      prod_q    <= prod_d;
      pvalid_q  <= pvalid_d;
      acc_q     <= acc_d;
      alive_q   <= 1'b1;
      busy_q    <= (state_d != IDLE);
      x_ready_q <= (state_d == RUN);
      y_valid_q <= (state_d == DONE);
    end
  end
endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Randomized self-checking bench for neuron_mac_ctrl with a behavioural BRAM
// and a plain-arithmetic dot-product reference model.
module tb_neuron_mac_ctrl;
  localparam int N_IN = 28;
  localparam int AW   = 5;
  localparam int DW   = 16;
  localparam int FRAC = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic          x_valid = 1'b0;
  logic [DW-1:0] x_data = '0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          y_ready = 1'b0;
  logic [DW-1:0] bram_do = '0;
  logic          busy, x_ready, ld_ready, ld_err, bram_en, bram_we, y_valid;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_di, y_data;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int rd_q[$];

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] wm     [0:N_IN-1];
  logic [DW-1:0] xs_cur [0:N_IN-1];

  neuron_mac_ctrl #(.N_IN(N_IN), .AW(AW), .DW(DW), .FRAC(FRAC)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .busy(busy),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_err(ld_err),
    .bram_addr(bram_addr), .bram_di(bram_di), .bram_en(bram_en),
    .bram_we(bram_we), .bram_do(bram_do),
    .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready)
  );

  always #5 CLK = ~CLK;

  // Falling-edge BRAM, read-first.
  always @(negedge CLK) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr] <= bram_di;
        wr_cnt++;
      end else begin
        bram_do <= mem[bram_addr];
        rd_q.push_back(int'(bram_addr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] ref_y();
    longint s = 0;
    for (int i = 0; i < N_IN; i++)
      s += longint'($signed(wm[i])) * longint'($signed(xs_cur[i]));
    s = s >>> FRAC;
    if (s > 32767)  return {1'b0, {(DW-1){1'b1}}};
    if (s < -32768) return {1'b1, {(DW-1){1'b0}}};
    return DW'(s);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
    start = 1'b0; ld_valid = 1'b1; ld_addr = a; ld_data = d;
    #1;
    n_cmp++;
    if ({ld_ready, ld_err, bram_en, bram_we, bram_addr, bram_di} !== {4'b1011, a, d}) begin
      n_bad++;
      $display("FAIL load_port: got rdy/err/en/we=%b%b%b%b addr=%0d di=%h, required 1011 addr=%0d di=%h",
               ld_ready, ld_err, bram_en, bram_we, bram_addr, bram_di, a, d);
    end
    tick();
    ld_valid = 1'b0;
    wm[a] = d;
  endtask

  task automatic begin_run();
    start = 1'b1; ld_valid = 1'b0;
    #1;
    n_cmp++;
    if ({ld_ready, bram_en, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL start_cycle: ld_ready=%b bram_en=%b busy=%b, required 000", ld_ready, bram_en, busy);
    end
    rd_q.delete();
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, x_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL enter_run: busy=%b x_ready=%b, required 11", busy, x_ready);
    end
  endtask

  task automatic run_and_check(input string nm, input int gap_pct, input int hold, input bit skip_begin);
    int k = 0;
    int guard = 0;
    int lat;
    logic [DW-1:0] exp_y, got_y;
    exp_y = ref_y();
    if (!skip_begin) begin_run();
    while (k < N_IN && guard < 4000) begin
      x_valid = ($urandom_range(99) >= gap_pct);
      x_data  = x_valid ? xs_cur[k] : DW'($urandom);
      start   = ($urandom_range(3) == 0);
      #1;
      if (x_valid && x_ready) k++;
      tick();
      guard++;
    end
    x_valid = 1'b0; start = 1'b0;
    n_cmp++;
    if (k != N_IN) begin
      n_bad++;
      $display("FAIL %s stream: handshakes=%0d, required %0d", nm, k, N_IN);
    end
    lat = 1;
    while (y_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat != 2) begin
      n_bad++;
      $display("FAIL %s latency: y_valid after %0d cycles, required 2", nm, lat);
    end
    got_y = y_data;
    n_cmp++;
    if (y_data !== exp_y) begin
      n_bad++;
      $display("FAIL %s result: y_data=%h, required %h", nm, y_data, exp_y);
    end
    n_cmp++;
    if (rd_q.size() != N_IN) begin
      n_bad++;
      $display("FAIL %s read_count: %0d strobes, required %0d", nm, rd_q.size(), N_IN);
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        n_cmp++;
        if (rd_q[i] != i) begin
          n_bad++;
          $display("FAIL %s read_addr: strobe %0d addr=%0d, required %0d", nm, i, rd_q[i], i);
        end
      end
    end
    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom_range(1)); x_valid = 1'b1; y_ready = 1'b0;
      #1;
      n_cmp++;
      if ({y_valid, busy, x_ready, bram_en, bram_we} !== 5'b11000 || y_data !== exp_y) begin
        n_bad++;
        $display("FAIL %s done_hold: vld/busy/xrdy/en/we=%b%b%b%b%b y=%h, required 11000 y=%h",
                 nm, y_valid, busy, x_ready, bram_en, bram_we, y_data, exp_y);
      end
      tick();
    end
    x_valid = 1'b0; y_ready = 1'b1; start = 1'b1;
    #1;
    n_cmp++;
    if (y_valid !== 1'b1 || y_data !== exp_y) begin
      n_bad++;
      $display("FAIL %s accept_cycle: y_valid=%b y=%h, required 1 y=%h", nm, y_valid, y_data, exp_y);
    end
    tick();
    y_ready = 1'b0; start = 1'b0;
    #1;
    n_cmp++;
    if ({busy, y_valid, x_ready} !== 3'b000 || y_data !== '0) begin
      n_bad++;
      $display("FAIL %s back_to_idle: busy/vld/xrdy=%b%b%b y=%h, required 000 y=0000", nm, busy, y_valid, x_ready, y_data);
    end
    $display("run %s: y_data=%h expected=%h latency=%0d", nm, got_y, exp_y, lat);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; start = 1'b1; ld_valid = 1'b1; ld_addr = '0; x_valid = 1'b1; y_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({busy, x_ready, ld_ready, ld_err, y_valid, bram_en, bram_we, bram_addr, bram_di, y_data} !== '0) begin
        n_bad++;
        $display("FAIL reset_hold: busy=%b xrdy=%b ldrdy=%b err=%b vld=%b en=%b we=%b addr=%h di=%h y=%h, required all 0",
                 busy, x_ready, ld_ready, ld_err, y_valid, bram_en, bram_we, bram_addr, bram_di, y_data);
      end
    end
    RST_N = 1'b1; start = 1'b0; x_valid = 1'b0; y_ready = 1'b0;
    #1;
    n_cmp++;
    if ({busy, x_ready, ld_ready, ld_err, y_valid, bram_en, bram_we, bram_addr, bram_di, y_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_first_cycle: busy=%b xrdy=%b ldrdy=%b err=%b vld=%b en=%b we=%b, required all 0",
               busy, x_ready, ld_ready, ld_err, y_valid, bram_en, bram_we);
    end
    ld_valid = 1'b0;
    tick();
  endtask

  task automatic test_unit();
    for (int i = 0; i < N_IN; i++) load_w(AW'(i), 16'h0100);
    for (int i = 0; i < N_IN; i++) xs_cur[i] = 16'h0100;
    run_and_check("unit", 0, 5, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < N_IN; i++) load_w(AW'(i), 16'h7FFF);
    for (int i = 0; i < N_IN; i++) xs_cur[i] = 16'h7FFF;
    run_and_check("sat_pos", 0, 2, 1'b0);
    for (int i = 0; i < N_IN; i++) load_w(AW'(i), 16'h8000);
    run_and_check("sat_neg", 0, 0, 1'b0);
  endtask

  task automatic test_ramp_gaps();
    for (int i = 0; i < N_IN; i++) load_w(AW'(i), DW'(i));
    for (int i = 0; i < N_IN; i++) xs_cur[i] = 16'h0100;
    run_and_check("ramp_gaps", 50, 1, 1'b0);
  endtask

  task automatic test_ld_err();
    int wc;
    logic [AW-1:0] bad [2];
    bad[0] = AW'(N_IN);
    bad[1] = '1;
    wc = wr_cnt;
    for (int b = 0; b < 2; b++) begin
      start = 1'b0; ld_valid = 1'b1; ld_addr = bad[b]; ld_data = DW'($urandom);
      #1;
      n_cmp++;
      if ({ld_ready, ld_err, bram_en, bram_we} !== 4'b1100) begin
        n_bad++;
        $display("FAIL ld_err_beat: addr=%0d rdy/err/en/we=%b%b%b%b, required 1100", ld_addr, ld_ready, ld_err, bram_en, bram_we);
      end
      tick();
      ld_valid = 1'b0;
      #1;
      n_cmp++;
      if (ld_err !== 1'b0) begin
        n_bad++;
        $display("FAIL ld_err_pulse: ld_err=%b after beat, required 0", ld_err);
      end
    end
    tick();
    n_cmp++;
    if (wr_cnt != wc) begin
      n_bad++;
      $display("FAIL ld_err_nowrite: writes=%0d, required 0", wr_cnt - wc);
    end
  endtask

  task automatic test_start_with_ld();
    int wc;
    wc = wr_cnt;
    for (int i = 0; i < N_IN; i++) xs_cur[i] = DW'($urandom);
    start = 1'b1; ld_valid = 1'b1; ld_addr = 3; ld_data = ~wm[3];
    #1;
    n_cmp++;
    if ({ld_ready, bram_en, bram_we} !== 3'b000) begin
      n_bad++;
      $display("FAIL start_ld_clash: ld_ready=%b en=%b we=%b, required 000", ld_ready, bram_en, bram_we);
    end
    rd_q.delete();
    tick();
    start = 1'b0; ld_valid = 1'b0;
    n_cmp++;
    if ({busy, x_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL start_ld_run: busy=%b x_ready=%b, required 11", busy, x_ready);
    end
    run_and_check("start_with_ld", 30, 0, 1'b1);
    n_cmp++;
    if (wr_cnt != wc) begin
      n_bad++;
      $display("FAIL start_ld_nowrite: writes=%0d, required 0", wr_cnt - wc);
    end
  endtask

  task automatic test_abort();
    begin_run();
    for (int k = 0; k < 10; k++) begin
      x_valid = 1'b1; x_data = DW'($urandom);
      tick();
    end
    x_valid = 1'b0;
    n_cmp++;
    if ({busy, x_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL abort_midrun: busy=%b x_ready=%b, required 11", busy, x_ready);
    end
    RST_N = 1'b0;
    tick();
    n_cmp++;
    if ({busy, x_ready, ld_ready, ld_err, y_valid, bram_en, bram_we, bram_addr, bram_di, y_data} !== '0) begin
      n_bad++;
      $display("FAIL abort_reset: busy=%b xrdy=%b vld=%b en=%b addr=%h y=%h, required all 0",
               busy, x_ready, y_valid, bram_en, bram_addr, y_data);
    end
    RST_N = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if ({busy, y_valid} !== 2'b00) begin
        n_bad++;
        $display("FAIL abort_no_result: busy=%b y_valid=%b, required 00", busy, y_valid);
      end
      tick();
    end
    for (int i = 0; i < N_IN; i++) xs_cur[i] = DW'($urandom_range(16'h0400));
    run_and_check("after_abort", 20, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N_IN; i++) load_w(AW'(i), DW'($urandom));
      for (int i = 0; i < N_IN; i++) xs_cur[i] = DW'($urandom);
      run_and_check($sformatf("random_%0d", r), $urandom_range(70), $urandom_range(3), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_unit();
    test_saturation();
    test_ramp_gaps();
    test_ld_err();
    test_start_with_ld();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
